// File: rtl/npu_inst_pkg.sv
// Shared types and widths for the NPU instruction path.
package npu_inst_pkg;

  localparam int unsigned INST_W  = 128;
  localparam int unsigned INST_AW = 12;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_FLUSH
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_fifo.sv
// Prefetch FIFO for inst_fetch: synchronous, DW x DEPTH, with a clear-all flush input.
module inst_fetch_fifo #(
  parameter int unsigned DW    = 128,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [DW-1:0]            wr_data,
  input  logic                     rd_en,
  output logic [DW-1:0]            rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;

  assign empty   = (count == '0);
  assign rd_data = mem[rptr];

  always_ff @(posedge clk) begin
    if (wr_en && !flush) begin
      mem[wptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_en) begin
        wptr <= wptr + 1'b1;
      end
      if (rd_en) begin
        rptr <= rptr + 1'b1;
      end
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch master: walks an inst_buffer address range and streams
// instructions to decode. Optional perf counters under INST_FETCH_PERF_EN.
module inst_fetch
  import npu_inst_pkg::*;
#(
  parameter int unsigned AW         = INST_AW,
  parameter int unsigned DW         = INST_W,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic [AW-1:0] i_start_addr,
  input  logic [AW:0]   i_inst_num,
  input  logic          i_abort,
  output logic          o_busy,
  output logic          o_done,
  output logic [AW-1:0] o_inst_raddr,
  output logic          o_inst_rd_en,
  input  logic [DW-1:0] i_inst_rdat,
  input  logic          i_inst_rdat_vld,
  output logic [DW-1:0] o_inst,
  output logic          o_inst_vld,
  input  logic          i_inst_rdy
`ifdef INST_FETCH_PERF_EN
  ,
  output logic [31:0]   o_stall_cnt,
  output logic [31:0]   o_bp_cnt
`endif
);

  localparam int unsigned CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [AW:0] NUM_ONE = {{AW{1'b0}}, 1'b1};

  fetch_state_e      state;
  fetch_state_e      state_nxt;
  logic [AW-1:0]     addr_q;
  logic [AW:0]       rd_left;
  logic [AW:0]       acc_left;
  logic [RD_LAT-1:0] vsr;
  logic              done_q;
  logic              done_nxt;
  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic [DW-1:0]     fifo_head;
  logic [15:0]       inflight;
  logic [15:0]       occupancy;
  logic              start_ok;
  logic              abort_ok;
  logic              rd_en;
  logic              cap;
  logic              pop;

  assign inflight  = 16'($countones(vsr));
  assign occupancy = 16'(fifo_count) + inflight;

  assign start_ok = i_start && (state == S_IDLE);
  assign abort_ok = i_abort && ((state == S_FETCH) || (state == S_DRAIN));

  // Credit covers FIFO entries plus reads still in the buffer pipe, so a
  // returning read always has a slot.
  assign rd_en = (state == S_FETCH) && !i_abort && (occupancy < 16'(FIFO_DEPTH));
  assign cap   = vsr[RD_LAT-1] && (state != S_FLUSH);
  assign pop   = !fifo_empty && i_inst_rdy;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start_ok) begin
          if (i_inst_num == '0) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        if (i_abort) begin
          state_nxt = S_FLUSH;
        end else if (rd_en && (rd_left == NUM_ONE)) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (i_abort) begin
          state_nxt = S_FLUSH;
        end else if (pop && (acc_left == NUM_ONE)) begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
        end
      end
      S_FLUSH: begin
        if (inflight == '0) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_q   <= '0;
      rd_left  <= '0;
      acc_left <= '0;
      vsr      <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= done_nxt;
      vsr[0] <= rd_en;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        vsr[i] <= vsr[i-1];
      end
      if (start_ok) begin
        addr_q   <= i_start_addr;
        rd_left  <= i_inst_num;
        acc_left <= i_inst_num;
      end else begin
        if (rd_en) begin
          addr_q  <= addr_q + 1'b1;
          rd_left <= rd_left - 1'b1;
        end
        if (pop && (acc_left != '0)) begin
          acc_left <= acc_left - 1'b1;
        end
      end
    end
  end

  inst_fetch_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .flush   (abort_ok),
    .wr_en   (cap),
    .wr_data (i_inst_rdat),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign o_busy       = (state != S_IDLE);
  assign o_done       = done_q;
  assign o_inst_raddr = addr_q;
  assign o_inst_rd_en = rd_en;
  assign o_inst_vld   = !fifo_empty;
  assign o_inst       = fifo_empty ? '0 : fifo_head;

  generate
    if (RD_LAT == 1) begin : g_vld_chk
      // Buffer valid is always one cycle after rd_en; only then must it track the pipe.
      a_vld_match : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        i_inst_rdat_vld == vsr[0]);
    end
  endgenerate

`ifdef INST_FETCH_PERF_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_stall_cnt <= '0;
      o_bp_cnt    <= '0;
    end else if (start_ok) begin
      o_stall_cnt <= '0;
      o_bp_cnt    <= '0;
    end else begin
      if (((state == S_FETCH) || (state == S_DRAIN)) && fifo_empty && (o_stall_cnt != '1)) begin
        o_stall_cnt <= o_stall_cnt + 32'd1;
      end
      if (!fifo_empty && !i_inst_rdy && (o_bp_cnt != '1)) begin
        o_bp_cnt <= o_bp_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: RD_LAT=1 and RD_LAT=2 instances share stimulus and are
// checked against an address-arithmetic reference of the expected stream.
module tb_inst_fetch;

  localparam int unsigned AW    = 12;
  localparam int unsigned DW    = 128;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 3000;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          start      = 1'b0;
  logic          abort      = 1'b0;
  logic          rdy        = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   inst_num   = '0;

  logic          busy     [2];
  logic          done     [2];
  logic          rd_en    [2];
  logic          rdat_vld [2];
  logic          inst_vld [2];
  logic [AW-1:0] raddr    [2];
  logic [DW-1:0] rdat     [2];
  logic [DW-1:0] inst     [2];
  logic [DW-1:0] stage1;
  logic [DW-1:0] mem      [4096];

`ifdef INST_FETCH_PERF_EN
  logic [31:0] stall_cnt [2];
  logic [31:0] bp_cnt    [2];
`endif

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned exp_base = 0;
  int unsigned exp_num  = 0;
  int unsigned rd_idx   [2];
  int unsigned acc_idx  [2];
  int unsigned done_cnt [2];
  int unsigned max_out  [2];
  int unsigned rdy_mode = 0;
  int unsigned cyc_cnt  = 0;

  inst_fetch #(.AW(AW), .DW(DW), .RD_LAT(1), .FIFO_DEPTH(DEPTH)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_start_addr(start_addr),
    .i_inst_num(inst_num), .i_abort(abort), .o_busy(busy[0]), .o_done(done[0]),
    .o_inst_raddr(raddr[0]), .o_inst_rd_en(rd_en[0]), .i_inst_rdat(rdat[0]),
    .i_inst_rdat_vld(rdat_vld[0]), .o_inst(inst[0]), .o_inst_vld(inst_vld[0]),
    .i_inst_rdy(rdy)
`ifdef INST_FETCH_PERF_EN
    , .o_stall_cnt(stall_cnt[0]), .o_bp_cnt(bp_cnt[0])
`endif
  );

  inst_fetch #(.AW(AW), .DW(DW), .RD_LAT(2), .FIFO_DEPTH(DEPTH)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_start_addr(start_addr),
    .i_inst_num(inst_num), .i_abort(abort), .o_busy(busy[1]), .o_done(done[1]),
    .o_inst_raddr(raddr[1]), .o_inst_rd_en(rd_en[1]), .i_inst_rdat(rdat[1]),
    .i_inst_rdat_vld(rdat_vld[1]), .o_inst(inst[1]), .o_inst_vld(inst_vld[1]),
    .i_inst_rdy(rdy)
`ifdef INST_FETCH_PERF_EN
    , .o_stall_cnt(stall_cnt[1]), .o_bp_cnt(bp_cnt[1])
`endif
  );

  // Buffer models: plain SRAM (1 cycle) and SRAM with output register (2 cycles).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdat[0]     <= '0;
      rdat_vld[0] <= 1'b0;
      rdat[1]     <= '0;
      rdat_vld[1] <= 1'b0;
      stage1      <= '0;
    end else begin
      rdat_vld[0] <= rd_en[0];
      if (rd_en[0]) rdat[0] <= mem[raddr[0]];
      rdat_vld[1] <= rd_en[1];
      if (rd_en[1]) stage1 <= mem[raddr[1]];
      rdat[1] <= stage1;
    end
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: the k-th read and k-th delivered word of a program are
  // address (base+k) mod 4096 and its preloaded contents.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        if (rd_en[d]) begin
          if (rd_idx[d] < exp_num)
            check($sformatf("raddr%0d", d), DW'(raddr[d]), DW'((exp_base + rd_idx[d]) % 4096));
          else
            check($sformatf("rd_extra%0d", d), 1, 0);
          rd_idx[d]++;
        end
        if (inst_vld[d] && rdy) begin
          if (acc_idx[d] < exp_num)
            check($sformatf("inst%0d", d), inst[d], mem[(exp_base + acc_idx[d]) % 4096]);
          else
            check($sformatf("inst_extra%0d", d), 1, 0);
          acc_idx[d]++;
        end
        if (busy[d]) begin
          check($sformatf("occupancy%0d", d), DW'((rd_idx[d] - acc_idx[d]) <= DEPTH), 1);
          if ((rd_idx[d] - acc_idx[d]) > max_out[d]) max_out[d] = rd_idx[d] - acc_idx[d];
        end
        if (done[d]) begin
          done_cnt[d]++;
          check($sformatf("busy_at_done%0d", d), DW'(busy[d]), 0);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc_cnt++;
      case (rdy_mode)
        0:       rdy = 1'b1;
        1:       rdy = ((cyc_cnt % 3) == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic clear_model(input int unsigned base, input int unsigned num);
    exp_base = base;
    exp_num  = num;
    for (int d = 0; d < 2; d++) begin
      rd_idx[d]   = 0;
      acc_idx[d]  = 0;
      done_cnt[d] = 0;
      max_out[d]  = 0;
    end
  endtask

  task automatic begin_prog(input int unsigned base, input int unsigned num);
    @(posedge clk);
    #1;
    clear_model(base, num);
    start      = 1'b1;
    start_addr = AW'(base);
    inst_num   = (AW + 1)'(num);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic finish_prog(input int unsigned num);
    int unsigned cyc;
    cyc = 0;
    while (((done_cnt[0] == 0) || (done_cnt[1] == 0)) && (cyc < TMO)) begin
      @(posedge clk);
      cyc++;
    end
    check("done_timeout", DW'(cyc < TMO), 1);
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("done_cnt%0d", d), DW'(done_cnt[d]), 1);
      check($sformatf("reads%0d", d), DW'(rd_idx[d]), DW'(num));
      check($sformatf("accepts%0d", d), DW'(acc_idx[d]), DW'(num));
      check($sformatf("busy_end%0d", d), DW'(busy[d]), 0);
    end
  endtask

  task automatic run(input int unsigned base, input int unsigned num, input int unsigned mode);
    rdy_mode = mode;
    begin_prog(base, num);
    finish_prog(num);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
    clear_model(0, 0);
    #1 rst_n = 1'b0;
    #20;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_busy%0d", d), DW'(busy[d]), 0);
      check($sformatf("rst_done%0d", d), DW'(done[d]), 0);
      check($sformatf("rst_rd_en%0d", d), DW'(rd_en[d]), 0);
      check($sformatf("rst_raddr%0d", d), DW'(raddr[d]), 0);
      check($sformatf("rst_vld%0d", d), DW'(inst_vld[d]), 0);
      check($sformatf("rst_inst%0d", d), inst[d], 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run(32'h010, 8, 0);
    run(32'hFFE, 4, 0);

    run($urandom_range(0, 4095), 16, 1);
    for (int d = 0; d < 2; d++)
      check($sformatf("credit_limit%0d", d), DW'(max_out[d]), DEPTH);

    repeat (6) run($urandom_range(0, 4095), $urandom_range(1, 40), $urandom_range(0, 2));

    // Abort with reads in flight.
    rdy_mode = 0;
    begin_prog(32'h200, 20);
    repeat (5) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    clear_model(0, 0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        check($sformatf("abort_vld%0d", d), DW'(inst_vld[d]), 0);
        if (c >= d + 2) check($sformatf("abort_busy%0d", d), DW'(busy[d]), 0);
      end
    end
    for (int d = 0; d < 2; d++) check($sformatf("abort_no_done%0d", d), DW'(done_cnt[d]), 0);
    run(32'h300, 10, 2);

    // Abort while idle is ignored.
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) check($sformatf("idle_abort_busy%0d", d), DW'(busy[d]), 0);

    // Zero-length program.
    begin_prog(32'h123, 0);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("zero_done%0d", d), DW'(done[d]), 1);
      check($sformatf("zero_busy%0d", d), DW'(busy[d]), 0);
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("zero_done_pulse%0d", d), DW'(done[d]), 0);
      check($sformatf("zero_reads%0d", d), DW'(rd_idx[d]), 0);
    end

    // Start while busy is ignored.
    rdy_mode = 2;
    begin_prog(32'h100, 12);
    repeat (3) @(posedge clk);
    #1;
    start      = 1'b1;
    start_addr = 12'h555;
    inst_num   = 13'd5;
    @(posedge clk);
    #1 start = 1'b0;
    finish_prog(12);

    rdy_mode = 0;
    run(32'h010, 8, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
